// File: rtl/seq_pattern_tx_if.sv
// Producer-side handshake and serial-link signals of the frame transmitter.
// master: parallel producer; slave: seq_pattern_tx.
interface seq_pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              dout;
  logic              busy;
  logic              frame_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, dout, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, dout, busy, frame_done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: preamble (MSB first), payload word (MSB first), idle gap.
// Optional even-parity bit after the payload when SEQ_PATTERN_TX_PARITY_EN is defined.
module seq_pattern_tx #(
  parameter int              DATA_W     = 8,
  parameter int              PRE_W      = 3,
  parameter logic [PRE_W-1:0] PREAMBLE  = 3'b101,
  parameter int              GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  bus
);

  localparam int FRAME_W = PRE_W + DATA_W;
  localparam int MAX_PD  = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_LEN = (MAX_PD > GAP_CYCLES) ? MAX_PD : GAP_CYCLES;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
`ifdef SEQ_PATTERN_TX_PARITY_EN
    S_PAR  = 3'd3,
`endif
    S_GAP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               in_ready_q, in_ready_d;

`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic par_q, par_d;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction
`endif

  // Next-state, shift and counter logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // First preamble bit goes straight to dout; the shifter holds the rest of the frame.
          state_d = S_PRE;
          cnt_d   = '0;
          shreg_d = {PREAMBLE[PRE_W-1:0], bus.in_data};
          shreg_d = {shreg_d[FRAME_W-2:0], 1'b0};
          dout_d  = PREAMBLE[PRE_W-1];
`ifdef SEQ_PATTERN_TX_PARITY_EN
          par_d   = even_parity(bus.in_data);
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        dout_d  = shreg_q[FRAME_W-1];
        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        if (cnt_q == PRE_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
          state_d = S_PAR;
          dout_d  = par_q;
`else
          state_d = S_GAP;
          dout_d  = 1'b0;
`endif
        end else begin
          dout_d  = shreg_q[FRAME_W-1];
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
        end
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      S_PAR: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
`endif
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d       = (state_d != S_IDLE);
    in_ready_d   = (state_d == S_IDLE);
    frame_done_d = (state_d == S_GAP) && (cnt_d == GAP_LAST);
  end

  // State and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= in_ready_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.in_ready   = in_ready_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a frame-list model checked every cycle,
// plus hand-computed wire patterns for specific words.
module tb_seq_pattern_tx;

  localparam int DATA_W = 8;
  localparam int PRE_W  = 3;
  localparam int GAP    = 2;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int PAR_BITS   = 1;
  localparam int B2B_SPACE  = 15;
  localparam logic BIT11_01 = 1'b1;
`else
  localparam int PAR_BITS   = 0;
  localparam int B2B_SPACE  = 14;
  localparam logic BIT11_01 = 1'b0;
`endif
  localparam int FLEN  = PRE_W + DATA_W + PAR_BITS;
  localparam int TOTAL = FLEN + GAP;
  localparam int TR_N  = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seq_pattern_tx_if #(.DATA_W(DATA_W)) bus ();

  seq_pattern_tx #(
    .DATA_W(DATA_W), .PRE_W(PRE_W), .PREAMBLE(3'b101), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pos = -1;
  int acc_cyc = 0;
  int n_acc = 0;
  logic exp_bits [0:TOTAL-1];
  logic tr_dout  [0:TR_N-1];
  logic tr_done  [0:TR_N-1];
  logic tr_ready [0:TR_N-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a list of wire bits; pos walks it one cycle at a time.
  initial begin
    logic [2:0] pre_pat;
    logic [DATA_W-1:0] w;
    int ones;
    pre_pat = 3'b101;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        pos = -1;
      end else if (pos >= 0) begin
        pos++;
        if (pos == TOTAL) pos = -1;
      end else if (bus.in_valid) begin
        w = bus.in_data;
        ones = 0;
        for (int i = 0; i < TOTAL; i++) exp_bits[i] = 1'b0;
        for (int i = 0; i < PRE_W; i++) exp_bits[i] = pre_pat[PRE_W-1-i];
        for (int i = 0; i < DATA_W; i++) begin
          exp_bits[PRE_W+i] = w[DATA_W-1-i];
          if (w[DATA_W-1-i]) ones++;
        end
        if (PAR_BITS == 1) exp_bits[PRE_W+DATA_W] = ((ones % 2) == 1);
        pos = 0;
        acc_cyc = cyc + 1;
        n_acc++;
      end
    end
  end

  // Every-cycle comparison against the model, plus a trace for pattern checks.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc < TR_N) begin
        tr_dout[cyc]  = bus.dout;
        tr_done[cyc]  = bus.frame_done;
        tr_ready[cyc] = bus.in_ready;
      end
      check("dout", {31'd0, bus.dout}, (pos >= 0) ? {31'd0, exp_bits[pos]} : 32'd0);
      check("busy", {31'd0, bus.busy}, {31'd0, pos >= 0});
      check("frame_done", {31'd0, bus.frame_done}, {31'd0, pos == TOTAL-1});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, pos < 0});
    end
  end

  task automatic send(input logic [DATA_W-1:0] w, input bit hold, output int a);
    int old;
    bit got;
    old = n_acc;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #2;
      if (n_acc != old) got = 1'b1;
    end
    check("accept", {31'd0, got}, 32'd1);
    a = acc_cyc;
    bus.in_data = ~w;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  initial begin
    int t, a1, a2, b, zeros;
    logic [10:0] bits11;
    logic [7:0] pay;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dout", {31'd0, bus.dout}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Single frame 8'hA5
    send(8'hA5, 1'b0, t);
    repeat (TOTAL + 3) @(posedge clk);
    #2;
    for (int i = 0; i < 11; i++) bits11[10-i] = tr_dout[t+i];
    check("a5_bits", {21'd0, bits11}, {21'd0, 11'b10110100101});
    check("a5_bit11", {31'd0, tr_dout[t+11]}, 32'd0);
    check("a5_done", {31'd0, tr_done[t+TOTAL-1]}, 32'd1);
    check("a5_done_early", {31'd0, tr_done[t+TOTAL-2]}, 32'd0);
    check("a5_ready_low", {31'd0, tr_ready[t+TOTAL-1]}, 32'd0);
    check("a5_ready", {31'd0, tr_ready[t+TOTAL]}, 32'd1);

    // Back-to-back 8'hFF then 8'h00 with in_valid held
    send(8'hFF, 1'b1, a1);
    send(8'h00, 1'b0, a2);
    repeat (TOTAL + 3) @(posedge clk);
    #2;
    check("b2b_spacing", a2 - a1, B2B_SPACE);
    zeros = 0;
    for (int i = a1 + FLEN; i < a2; i++) if (tr_dout[i] == 1'b0) zeros++;
    check("b2b_zeros", zeros, 3);
    check("b2b_second_pre", {31'd0, tr_dout[a2]}, 32'd1);

    // Word 8'h01: bit after payload is parity (1) or gap (0)
    send(8'h01, 1'b0, t);
    repeat (TOTAL + 3) @(posedge clk);
    #2;
    check("w01_lastdata", {31'd0, tr_dout[t+10]}, 32'd1);
    check("w01_bit11", {31'd0, tr_dout[t+11]}, {31'd0, BIT11_01});

    // Reset on the 3rd payload bit of 8'hE0
    send(8'hE0, 1'b0, t);
    repeat (5) @(posedge clk);
    #2;
    check("mid_dout", {31'd0, bus.dout}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_dout", {31'd0, bus.dout}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.frame_done}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
    send(8'h96, 1'b0, b);
    repeat (TOTAL + 3) @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) pay[7-i] = tr_dout[b+3+i];
    check("post_rst_payload", {24'd0, pay}, 32'h96);
    check("post_rst_pre", {29'd0, tr_dout[b], tr_dout[b+1], tr_dout[b+2]}, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
